// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache port arbiter.
//   state_e  : arbiter FSM states (IDLE / BUSY / RESP)
//   PORT_M0  : requester id of the instruction-fetch port
//   PORT_M1  : requester id of the data load/store port
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker (purely combinational).
// Ports:
//   req_i        [1:0] request vector, bit 0 = m0, bit 1 = m1
//   last_grant_i       id of the requester granted most recently
//   gnt_valid_o        at least one request is present
//   gnt_id_o           id of the winning requester
module rr_arb2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        if (req_i == 2'b11) begin
            // Tie: the requester that did not win last time goes first.
            gnt_id_o = ~last_grant_i;
        end else if (req_i[1]) begin
            gnt_id_o = PORT_M1;
        end else begin
            gnt_id_o = PORT_M0;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single cache_controller request port between m0 (instruction
// fetch) and m1 (data load/store). One op is outstanding at a time; the
// granted request is held on the cache port until c_ready or a watchdog
// timeout, then a one-cycle ack (plus read data / error) goes back.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   mX_req/rw/addr/wdata     requester X op (held until mX_ack)
//   mX_ack, mX_rdata         requester X completion pulse and read data
//   c_req/rw/addr/wdata      request to the cache, held until c_ready
//   c_rdata, c_ready         cache read data and completion pulse
//   ack_err                  current ack is for a timed-out op
//   err_timeout              sticky timeout flag
//   gnt_cnt0, gnt_cnt1       wrapping grant counters per requester
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_rw,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_rw,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          c_req,
    output logic          c_rw,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_wdata,
    input  logic [DW-1:0] c_rdata,
    input  logic          c_ready,
    output logic          ack_err,
    output logic          err_timeout,
    output logic [CW-1:0] gnt_cnt0,
    output logic [CW-1:0] gnt_cnt1
);

    localparam int             WDW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYC - 1);

    state_e          state_q;
    logic            last_grant_q;
    logic            gnt_id_q;
    logic [WDW-1:0]  wdog_q;
    logic            c_req_q;
    logic            c_rw_q;
    logic [AW-1:0]   c_addr_q;
    logic [DW-1:0]   c_wdata_q;
    logic            m0_ack_q;
    logic            m1_ack_q;
    logic [DW-1:0]   m0_rdata_q;
    logic [DW-1:0]   m1_rdata_q;
    logic            ack_err_q;
    logic            err_timeout_q;
    logic [CW-1:0]   gnt_cnt0_q;
    logic [CW-1:0]   gnt_cnt1_q;

    logic            pick_valid;
    logic            pick_id;

    rr_arb2 u_rr_arb2 (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (pick_valid),
        .gnt_id_o     (pick_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= PORT_M1;   // m0 wins the first tie
            gnt_id_q      <= PORT_M0;
            wdog_q        <= '0;
            c_req_q       <= 1'b0;
            c_rw_q        <= 1'b0;
            c_addr_q      <= '0;
            c_wdata_q     <= '0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            ack_err_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            gnt_cnt0_q    <= '0;
            gnt_cnt1_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_id_q <= pick_id;
                        c_req_q  <= 1'b1;
                        wdog_q   <= '0;
                        state_q  <= ST_BUSY;
                        if (pick_id == PORT_M0) begin
                            c_rw_q     <= m0_rw;
                            c_addr_q   <= m0_addr;
                            c_wdata_q  <= m0_wdata;
                            gnt_cnt0_q <= gnt_cnt0_q + CW'(1);
                        end else begin
                            c_rw_q     <= m1_rw;
                            c_addr_q   <= m1_addr;
                            c_wdata_q  <= m1_wdata;
                            gnt_cnt1_q <= gnt_cnt1_q + CW'(1);
                        end
                    end
                end

                ST_BUSY: begin
                    wdog_q <= wdog_q + WDW'(1);
                    // c_ready has priority over a watchdog expiry in the same cycle.
                    if (c_ready) begin
                        c_req_q   <= 1'b0;
                        ack_err_q <= 1'b0;
                        state_q   <= ST_RESP;
                        if (gnt_id_q == PORT_M0) begin
                            m0_ack_q   <= 1'b1;
                            m0_rdata_q <= c_rdata;
                        end else begin
                            m1_ack_q   <= 1'b1;
                            m1_rdata_q <= c_rdata;
                        end
                    end else if (wdog_q == WDOG_LAST) begin
                        // Abandon the op: ack with error and zero data.
                        c_req_q       <= 1'b0;
                        ack_err_q     <= 1'b1;
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_RESP;
                        if (gnt_id_q == PORT_M0) begin
                            m0_ack_q   <= 1'b1;
                            m0_rdata_q <= '0;
                        end else begin
                            m1_ack_q   <= 1'b1;
                            m1_rdata_q <= '0;
                        end
                    end
                end

                ST_RESP: begin
                    // Ack is visible during this state only; requests are not sampled here.
                    m0_ack_q     <= 1'b0;
                    m1_ack_q     <= 1'b0;
                    ack_err_q    <= 1'b0;
                    last_grant_q <= gnt_id_q;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign c_req       = c_req_q;
    assign c_rw        = c_rw_q;
    assign c_addr      = c_addr_q;
    assign c_wdata     = c_wdata_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign ack_err     = ack_err_q;
    assign err_timeout = err_timeout_q;
    assign gnt_cnt0    = gnt_cnt0_q;
    assign gnt_cnt1    = gnt_cnt1_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter. Inputs change 1 time unit after
// each rising edge; outputs are checked at that same point.
module tb_cache_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_rw, m0_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_rw, m1_ack;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        c_req, c_rw, c_ready;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        ack_err, err_timeout;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    cache_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT_CYC(64), .CW(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (m0_req),
        .m0_rw       (m0_rw),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_ack      (m0_ack),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_rw       (m1_rw),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_ack      (m1_ack),
        .m1_rdata    (m1_rdata),
        .c_req       (c_req),
        .c_rw        (c_rw),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata),
        .c_rdata     (c_rdata),
        .c_ready     (c_ready),
        .ack_err     (ack_err),
        .err_timeout (err_timeout),
        .gnt_cnt0    (gnt_cnt0),
        .gnt_cnt1    (gnt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, summary not printed normally");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        logic       early;
        logic       exp_m1;
        logic [1:0] acks;

        rst = 1'b1;
        m0_req = 0; m0_rw = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_rw = 0; m1_addr = '0; m1_wdata = '0;
        c_rdata = '0; c_ready = 0;
        #2;
        rst = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_c_req",       32'(c_req), 32'd0);
        chk("rst_c_addr",      c_addr, 32'd0);
        chk("rst_acks",        32'({m1_ack, m0_ack}), 32'd0);
        chk("rst_rdata0",      m0_rdata, 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_gnt_cnt",     32'({gnt_cnt1, gnt_cnt0}), 32'd0);
        rst = 1'b1;
        tick();

        // Test 1: m0 write, cache ready after 4 BUSY cycles
        m0_req = 1; m0_rw = 1; m0_addr = 32'h8000_0000; m0_wdata = 32'h1234_5678;
        tick();
        chk("t1_c_req",   32'(c_req), 32'd1);
        chk("t1_c_rw",    32'(c_rw), 32'd1);
        chk("t1_c_wdata", c_wdata, 32'h1234_5678);
        chk("t1_gnt0",    32'(gnt_cnt0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t1_c_addr_stable", c_addr, 32'h8000_0000);
            chk("t1_no_early_ack",  32'(m0_ack), 32'd0);
            tick();
        end
        chk("t1_c_addr_last", c_addr, 32'h8000_0000);
        c_ready = 1; c_rdata = 32'hDEAD_BEEF;
        tick();
        c_ready = 0;
        chk("t1_m0_ack",   32'(m0_ack), 32'd1);
        chk("t1_ack_err",  32'(ack_err), 32'd0);
        chk("t1_wr_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t1_c_req_dn", 32'(c_req), 32'd0);
        m0_req = 0;
        tick();
        chk("t1_ack_one_cycle", 32'(m0_ack), 32'd0);

        // Test 2: m0 read, 1-cycle cache
        m0_req = 1; m0_rw = 0; m0_addr = 32'h8000_0000;
        tick();
        chk("t2_c_rw", 32'(c_rw), 32'd0);
        c_ready = 1; c_rdata = 32'h1234_5678;
        tick();
        c_ready = 0;
        chk("t2_m0_ack",   32'(m0_ack), 32'd1);
        chk("t2_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t2_m1_ack",   32'(m1_ack), 32'd0);
        m0_req = 0;
        tick();
        chk("t2_gnt0", 32'(gnt_cnt0), 32'd2);

        // Test 3: simultaneous requests, 4 ops each, strict alternation
        do_reset();
        m0_req = 1; m0_rw = 0; m0_addr = 32'h0000_1000;
        m1_req = 1; m1_rw = 1; m1_addr = 32'h0000_2000; m1_wdata = 32'hCAFE_0001;
        for (int k = 0; k < 8; k++) begin
            exp_m1 = ((k % 2) == 1);
            tick();
            chk("t3_grant_addr", c_addr, exp_m1 ? 32'h0000_2000 : 32'h0000_1000);
            c_ready = 1; c_rdata = 32'h0000_1000 + 32'(k);
            tick();
            c_ready = 0;
            acks = {m1_ack, m0_ack};
            chk("t3_ack_port", 32'(acks), exp_m1 ? 32'd2 : 32'd1);
            chk("t3_rdata", exp_m1 ? m1_rdata : m0_rdata, 32'h0000_1000 + 32'(k));
            if (k == 7) begin
                m0_req = 0; m1_req = 0;
            end
            tick();
        end
        chk("t3_gnt0", 32'(gnt_cnt0), 32'd4);
        chk("t3_gnt1", 32'(gnt_cnt1), 32'd4);

        // Test 4: cache never responds -> timeout after 64 BUSY cycles
        m0_req = 1; m0_rw = 0; m0_addr = 32'h0000_3000;
        c_rdata = 32'hA5A5_A5A5;
        tick();
        early = 0;
        for (int i = 0; i < 63; i++) begin
            if (m0_ack || !c_req) early = 1;
            tick();
        end
        chk("t4_no_early_timeout", 32'(early), 32'd0);
        chk("t4_c_req_last_busy",  32'(c_req), 32'd1);
        tick();
        chk("t4_m0_ack",    32'(m0_ack), 32'd1);
        chk("t4_ack_err",   32'(ack_err), 32'd1);
        chk("t4_rdata_zero", m0_rdata, 32'd0);
        chk("t4_err_sticky", 32'(err_timeout), 32'd1);
        chk("t4_c_req_dn",  32'(c_req), 32'd0);
        m0_req = 0;
        tick();
        chk("t4_ack_err_clr", 32'(ack_err), 32'd0);
        m1_req = 1; m1_rw = 0; m1_addr = 32'h0000_4000;
        tick();
        chk("t4_next_addr", c_addr, 32'h0000_4000);
        c_ready = 1; c_rdata = 32'h0000_55AA;
        tick();
        c_ready = 0;
        chk("t4_next_ack",   32'(m1_ack), 32'd1);
        chk("t4_next_err",   32'(ack_err), 32'd0);
        chk("t4_next_rdata", m1_rdata, 32'h0000_55AA);
        m1_req = 0;
        tick();
        chk("t4_err_still", 32'(err_timeout), 32'd1);

        // Test 5: c_ready on the final watchdog cycle wins
        do_reset();
        chk("t5_err_cleared", 32'(err_timeout), 32'd0);
        m0_req = 1; m0_rw = 0; m0_addr = 32'h0000_5000;
        tick();
        early = 0;
        for (int i = 0; i < 63; i++) begin
            if (m0_ack) early = 1;
            tick();
        end
        chk("t5_no_early", 32'(early), 32'd0);
        c_ready = 1; c_rdata = 32'h0000_600D;
        tick();
        c_ready = 0;
        chk("t5_m0_ack",  32'(m0_ack), 32'd1);
        chk("t5_ack_err", 32'(ack_err), 32'd0);
        chk("t5_err_to",  32'(err_timeout), 32'd0);
        chk("t5_rdata",   m0_rdata, 32'h0000_600D);
        m0_req = 0;
        tick();

        // Test 6: reset mid-BUSY, then m1 alone, then a tie
        m0_req = 1; m0_addr = 32'h0000_7000;
        tick();
        tick();
        chk("t6_busy_c_req", 32'(c_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_c_req_async", 32'(c_req), 32'd0);
        m0_req = 0;
        c_ready = 1;
        tick();
        c_ready = 0;
        tick();
        chk("t6_no_ack_in_rst", 32'({m1_ack, m0_ack}), 32'd0);
        rst = 1'b1;
        tick();
        chk("t6_no_ack_after", 32'({m1_ack, m0_ack}), 32'd0);
        // Stray c_ready while idle must not produce an ack.
        c_ready = 1;
        tick();
        c_ready = 0;
        tick();
        chk("t6_stray_ready", 32'({m1_ack, m0_ack}), 32'd0);
        m1_req = 1; m1_rw = 1; m1_addr = 32'h0000_8000; m1_wdata = 32'h0000_0BEE;
        tick();
        chk("t6_m1_addr", c_addr, 32'h0000_8000);
        chk("t6_gnt1",    32'(gnt_cnt1), 32'd1);
        // Requester drops while granted; op still completes.
        m1_req = 0;
        tick();
        c_ready = 1; c_rdata = 32'h0000_0077;
        tick();
        c_ready = 0;
        chk("t6_m1_ack", 32'(m1_ack), 32'd1);
        tick();
        m0_req = 1; m0_rw = 0; m0_addr = 32'h0000_9000;
        m1_req = 1; m1_rw = 0; m1_addr = 32'h0000_A000;
        tick();
        chk("t6_tie_addr", c_addr, 32'h0000_9000);
        chk("t6_tie_gnt0", 32'(gnt_cnt0), 32'd1);
        c_ready = 1; c_rdata = 32'h0000_0099;
        tick();
        c_ready = 0;
        chk("t6_tie_ack", 32'({m1_ack, m0_ack}), 32'd1);
        m0_req = 0; m1_req = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
